// File: rtl/msft_dvip_bram_arb_pkg.sv
// rtl/msft_dvip_bram_arb_pkg.sv - shared types and helpers for the DVP block-RAM arbiter
package msft_dvip_bram_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Widest supported data path in bytes; callers cast to their own width.
    localparam int MAX_BYTES = 64;

    function automatic logic [MAX_BYTES*8-1:0] be_to_bitmask(input logic [MAX_BYTES-1:0] be);
        logic [MAX_BYTES*8-1:0] mask;
        for (int i = 0; i < MAX_BYTES; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/msft_dvip_rr_arb2.sv
// rtl/msft_dvip_rr_arb2.sv - two-way round-robin grant with last-grant memory
module msft_dvip_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // On conflict the port that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/msft_dvip_bram_arbiter.sv
// rtl/msft_dvip_bram_arbiter.sv - two-requester round-robin controller for the block-RAM read/write port
module msft_dvip_bram_arbiter
    import msft_dvip_bram_arb_pkg::*;
#(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = $clog2(RAM_DEPTH),
    localparam int NB            = RAM_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_we,
    input  logic [AW-1:0]        req0_addr,
    input  logic [NB-1:0]        req0_be,
    input  logic [RAM_WIDTH-1:0] req0_wdata,
    output logic                 rsp0_valid,
    output logic [RAM_WIDTH-1:0] rsp0_rdata,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_we,
    input  logic [AW-1:0]        req1_addr,
    input  logic [NB-1:0]        req1_be,
    input  logic [RAM_WIDTH-1:0] req1_wdata,
    output logic                 rsp1_valid,
    output logic [RAM_WIDTH-1:0] rsp1_rdata,
    input  logic                 clear_req,
    output logic                 init_done,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [RAM_WIDTH-1:0] ram_wstrb,
    output logic [RAM_WIDTH-1:0] ram_din,
    input  logic [RAM_WIDTH-1:0] ram_dout
);

    state_t              state, state_nx;
    logic [AW-1:0]       clr_addr;
    logic                clear_pend;
    logic                rsp_valid_q, rsp_port_q, rsp_is_read_q;
    logic                run;
    logic [1:0]          grant;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [NB-1:0]       sel_be;
    logic [RAM_WIDTH-1:0] sel_wdata;
    logic [RAM_WIDTH-1:0] rsp_data;

    assign run = (state == RUN) && !rst;

    msft_dvip_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid} & {2{run}}),
        .advance (run),
        .grant   (grant)
    );

    always_comb begin
        sel_we    = grant[1] ? req1_we    : req0_we;
        sel_addr  = grant[1] ? req1_addr  : req0_addr;
        sel_be    = grant[1] ? req1_be    : req0_be;
        sel_wdata = grant[1] ? req1_wdata : req0_wdata;
    end

    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wstrb = '0;
        ram_din   = '0;
        if (!rst && state == CLEAR) begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wstrb = '1;
        end else if (grant != 2'b00) begin
            ram_cs    = 1'b1;
            ram_we    = sel_we;
            ram_addr  = sel_addr;
            ram_din   = sel_wdata;
            ram_wstrb = RAM_WIDTH'(be_to_bitmask(MAX_BYTES'(sel_be & {NB{sel_we}})));
        end
    end

    // A clear request that collides with an outgoing response waits one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (clr_addr == AW'(RAM_DEPTH - 1)) state_nx = RUN;
            RUN:     if (clear_pend || (clear_req && !rsp_valid_q)) state_nx = CLEAR;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_addr      <= '0;
            clear_pend    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_port_q    <= 1'b0;
            rsp_is_read_q <= 1'b0;
        end else begin
            state         <= state_nx;
            clr_addr      <= (state == CLEAR && state_nx == CLEAR) ? clr_addr + 1'b1 : '0;
            clear_pend    <= (state == RUN) && clear_req && rsp_valid_q && !clear_pend;
            rsp_valid_q   <= (grant != 2'b00);
            rsp_port_q    <= grant[1];
            rsp_is_read_q <= !sel_we;
        end
    end

    assign init_done  = run;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign rsp_data   = (rsp_valid_q && rsp_is_read_q && !rst) ? ram_dout : '0;
    assign rsp0_valid = rsp_valid_q && !rst && !rsp_port_q;
    assign rsp1_valid = rsp_valid_q && !rst && rsp_port_q;
    assign rsp0_rdata = rsp0_valid ? rsp_data : '0;
    assign rsp1_rdata = rsp1_valid ? rsp_data : '0;

endmodule

// File: doc/msft_dvip_bram_arbiter.md
# msft_dvip_bram_arbiter

Two-requester controller for the single-port read/write side of the DVP FPGA block-RAM model. It arbitrates round-robin between a primary requester (port 0, typically CPU data side) and a secondary requester (port 1, typically DMA or debug loader). It expands byte strobes to the RAM's per-bit write mask and returns read data with fixed latency. An optional post-reset clear engine zero-fills the RAM before traffic is admitted. The RAM's read-only second port is not routed through this block.

## Interface
Parameters:
- RAM_WIDTH, 32, data width; must be a multiple of 8.
- RAM_DEPTH, 1024, words; AW = $clog2(RAM_DEPTH).
- CLEAR_ON_RESET, 1, when 1, zero-fill the RAM after reset before accepting requests.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- reqN_valid  in  1  request valid; N = 0, 1. Same for all reqN_* and rspN_* ports below.
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  AW  word address.
- reqN_be  in  RAM_WIDTH/8  byte enables; writes only.
- reqN_wdata  in  RAM_WIDTH  write data.
- rspN_valid  out  1  response pulse, for both reads and writes.
- rspN_rdata  out  RAM_WIDTH  read data; 0 for write responses.
- clear_req  in  1  pulse; re-runs the zero-fill. Ignored while clearing.
- init_done  out  1  high when requests may be granted.
- ram_cs / ram_we  out  1  RAM port controls.
- ram_addr  out  AW  RAM address.
- ram_wstrb  out  RAM_WIDTH  per-bit write mask.
- ram_din  out  RAM_WIDTH  RAM write data.
- ram_dout  in  RAM_WIDTH  RAM registered read data.

## Operation
- States: CLEAR, RUN.
  - After rst: CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR → RUN after writing address RAM_DEPTH-1.
  - RUN → CLEAR on clear_req, if no response is pending this cycle. Otherwise entry is deferred one cycle; clear_req is latched.
- CLEAR:
  - clr_addr counter starts at 0.
  - Each cycle drives ram_cs=1, ram_we=1, ram_wstrb=all ones, ram_din=0, ram_addr=clr_addr; clr_addr increments.
  - Both reqN_ready=0; init_done=0.
- RUN:
  - init_done=1.
  - Grant is combinational from the two valids and last_grant (0 or 1).
  - Single valid: that port is granted.
  - Both valid: grant goes to the port other than last_grant.
  - last_grant updates to the granted port on every grant.
- Granted port N:
  - reqN_ready=1; ram_cs=1; ram_we=reqN_we; ram_addr=reqN_addr; ram_din=reqN_wdata.
  - ram_wstrb bit i = reqN_be[i/8] & reqN_we.
- No grant: ram_cs=0, with all other RAM outputs 0.
- Requesters hold valid and payload stable until ready. The block never drops a valid request, and the losing port is granted no later than the next cycle.
- Response tracking: the block registers rsp_port and rsp_is_read at each grant.
  - rspN_valid is asserted the cycle after the grant.
  - rspN_rdata = ram_dout for reads, 0 for writes.
- There is no response backpressure.
- reqN_be=0 with we=1 is a legal no-op write and still gets a response.

## Timing
- Reset values:
  - reqN_ready=0, rspN_valid=0, rspN_rdata=0.
  - ram_cs=0, ram_we=0.
  - init_done=0, last_grant=1, so port 0 wins the first conflict.
  - clr_addr=0.
- rst asserted mid-clear or mid-transaction: state restarts per CLEAR_ON_RESET and the pending response is discarded (no rsp_valid).
- Throughput: one grant per cycle; back-to-back grants to the same or alternating ports.
- Read latency: grant in cycle T, rspN_valid and data in T+1.
- Write: RAM updated at the T→T+1 edge; ack in T+1. A read of the same address granted in T+1 returns the new data in T+2.
- Clear duration: exactly RAM_DEPTH cycles.
  - With CLEAR_ON_RESET=1, the first grant is possible at cycle RAM_DEPTH after rst deassertion.
  - With CLEAR_ON_RESET=0, the first grant is possible at cycle 0.
- Response for the grant in the last RUN cycle before a clear_req-triggered CLEAR is still delivered.

## Structure
- Package msft_dvip_bram_arb_pkg:
  - state enum {CLEAR, RUN};
  - function be_to_bitmask(be) expanding byte enables to the bit mask.
- Sub-module msft_dvip_rr_arb2: 2-way round-robin grant with last_grant register; inputs valid[1:0], advance; outputs grant one-hot.

## Test plan
- Reset with CLEAR_ON_RESET=1, RAM pre-loaded 0xFFFFFFFF: init_done rises exactly 1024 cycles after rst falls; read of addr 0x3FF returns 0.
- Port 0 writes 0xDEADBEEF to addr 5 with be=4'b0011, then reads addr 5: rsp0_valid on each cycle after grant; rdata=0x0000BEEF.
- Both valid continuously, reads to addrs 1 (port 0) and 2 (port 1) holding 0x11 and 0x22: grants alternate 0,1,0,1…; every rsp carries the correct port's data; no cycle idles.
- Port 1 read granted at T, clear_req at T: rsp1_valid at T+1 with correct data, CLEAR entered at T+1, init_done low for 1024 cycles, ready never asserted meanwhile.
- rst asserted during CLEAR at clr_addr=300: after release the clear restarts from 0 and takes the full 1024 cycles.
- CLEAR_ON_RESET=0: port 0 write granted in the first cycle after reset; be=0 write leaves data unchanged and returns rsp0_valid with rdata=0.
